// File: rtl/instr_store_pkg.sv
// Shared definitions for the loadable instruction store: FSM encoding, default fill word and
// the even-parity helper used when INSTR_PARITY_EN is defined.
package instr_store_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam logic [20:0] DEFAULT_FILL_WORD = 21'h1C0009;

    // Returns the bit that makes the total number of ones (data plus bit) even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/instr_store_ram.sv
// Single write port, single registered read port storage array for instr_store.
// The array itself has no reset; the top fills it after reset.
module instr_store_ram #(
    parameter int unsigned WIDTH  = 21,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Callers keep both addresses below DEPTH, so the low IDX_W bits are the full index.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i[IDX_W-1:0]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_store.sv
// Parametrised loadable instruction store: fill on reset, registered fetch with stall, burst load.
// Optional per-word even parity is enabled by defining INSTR_PARITY_EN.
module instr_store
    import instr_store_pkg::*;
#(
    parameter int unsigned         INSTR_W   = 21,
    parameter int unsigned         ADDR_W    = 8,
    parameter int unsigned         DEPTH     = 2 ** ADDR_W,
    parameter logic [INSTR_W-1:0]  FILL_WORD = INSTR_W'(DEFAULT_FILL_WORD)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               fetch_req_i,
    input  logic [ADDR_W-1:0]  fetch_addr_i,
    input  logic               stall_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               instr_valid_o,
    input  logic               ld_start_i,
    input  logic [ADDR_W-1:0]  ld_base_i,
    input  logic [INSTR_W-1:0] ld_data_i,
    input  logic               ld_valid_i,
    input  logic               ld_last_i,
    output logic               ld_ready_o,
    output logic               busy_o
`ifdef INSTR_PARITY_EN
   ,output logic               par_err_o
   ,input  logic               ld_par_inv_i
`endif
);

`ifdef INSTR_PARITY_EN
    localparam int unsigned          WORD_W     = INSTR_W + 1;
    localparam logic [WORD_W-1:0]    FILL_ENTRY = {even_parity(64'(FILL_WORD)), FILL_WORD};
`else
    localparam int unsigned          WORD_W     = INSTR_W;
    localparam logic [WORD_W-1:0]    FILL_ENTRY = FILL_WORD;
`endif
    localparam logic [ADDR_W-1:0]    LAST_ADDR  = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic              fill_sel_q, fill_sel_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_re;
    logic [WORD_W-1:0] ram_rdata;
    logic              fetch_go;
    logic              addr_in_range;
    logic              par_bad;
    logic [WORD_W-1:0] load_entry;

`ifdef INSTR_PARITY_EN
    assign load_entry = {even_parity(64'(ld_data_i)) ^ ld_par_inv_i, ld_data_i};
`else
    assign load_entry = ld_data_i;
`endif

    assign addr_in_range = 32'(fetch_addr_i) < DEPTH;
    assign fetch_go      = (state_q == ST_RUN) && fetch_req_i && !stall_i;
    assign ram_re        = fetch_go && addr_in_range;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ptr_d      = ptr_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;

        unique case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_cnt_q;
                ram_wdata = FILL_ENTRY;
                if (init_cnt_q == LAST_ADDR) begin
                    init_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (ld_start_i) begin
                    ptr_d   = ADDR_W'(32'(ld_base_i) % DEPTH);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_valid_i) begin
                    ram_we    = 1'b1;
                    ram_waddr = ptr_q;
                    ram_wdata = load_entry;
                    ptr_d     = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
                    if (ld_last_i) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Stall freezes the result; otherwise a served request (or none) decides the new state.
    always_comb begin
        valid_d    = stall_i ? valid_q : fetch_go;
        fill_sel_d = fill_sel_q;
        if (fetch_go) begin
            fill_sel_d = !addr_in_range;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            fill_sel_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            fill_sel_q <= fill_sel_d;
        end
    end

    instr_store_ram #(
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (fetch_addr_i),
        .rdata_o (ram_rdata)
    );

    // The RAM read register doubles as the instruction register; only the select is tracked here.
`ifdef INSTR_PARITY_EN
    assign par_bad   = !fill_sel_q && even_parity(64'(ram_rdata));
    assign par_err_o = valid_q && par_bad;
`else
    assign par_bad   = 1'b0;
`endif

    assign instruction_o = (fill_sel_q || par_bad) ? FILL_WORD : ram_rdata[INSTR_W-1:0];
    assign instr_valid_o = valid_q;
    assign ld_ready_o    = (state_q == ST_LOAD);
    assign busy_o        = (state_q != ST_RUN);

endmodule

// File: tb/tb_instr_store.sv
// Self-checking bench for instr_store: a DEPTH=256 and a DEPTH=200 instance share stimulus and
// are compared each cycle against an array-based reference model.
module tb_instr_store;

    localparam logic [20:0] FILL = 21'h1C0009;
    localparam int M_INIT = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOAD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [7:0]  fetch_addr = '0;
    logic        stall = 1'b0;
    logic        ld_start = 1'b0;
    logic [7:0]  ld_base = '0;
    logic [20:0] ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic        ld_par_inv = 1'b0;

    logic [20:0] instr_w [2];
    logic        valid_w [2];
    logic        ready_w [2];
    logic        busy_w  [2];
`ifdef INSTR_PARITY_EN
    logic        perr_w  [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [20:0] mmem [2][256];
    bit          mbad [2][256];
    int          mstate [2];
    int          micnt [2];
    int          mptr [2];
    logic [20:0] einstr [2];
    bit          evalid [2];
    bit          eperr [2];
    int          depth [2] = '{256, 200};

    always #5 clk = ~clk;

    instr_store #(.DEPTH(256)) dut0 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .stall_i       (stall),
        .instruction_o (instr_w[0]),
        .instr_valid_o (valid_w[0]),
        .ld_start_i    (ld_start),
        .ld_base_i     (ld_base),
        .ld_data_i     (ld_data),
        .ld_valid_i    (ld_valid),
        .ld_last_i     (ld_last),
        .ld_ready_o    (ready_w[0]),
        .busy_o        (busy_w[0])
`ifdef INSTR_PARITY_EN
       ,.par_err_o     (perr_w[0])
       ,.ld_par_inv_i  (ld_par_inv)
`endif
    );

    instr_store #(.DEPTH(200)) dut1 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .stall_i       (stall),
        .instruction_o (instr_w[1]),
        .instr_valid_o (valid_w[1]),
        .ld_start_i    (ld_start),
        .ld_base_i     (ld_base),
        .ld_data_i     (ld_data),
        .ld_valid_i    (ld_valid),
        .ld_last_i     (ld_last),
        .ld_ready_o    (ready_w[1]),
        .busy_o        (busy_w[1])
`ifdef INSTR_PARITY_EN
       ,.par_err_o     (perr_w[1])
       ,.ld_par_inv_i  (ld_par_inv)
`endif
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mstate[k] = M_INIT;
            micnt[k]  = 0;
            einstr[k] = FILL;
            evalid[k] = 1'b0;
            eperr[k]  = 1'b0;
        end
    endtask

    // One clock edge of the behaviour: fetch sees memory as it was before this edge's write.
    task automatic model_step(input int k);
        int d = depth[k];
        if (!stall) begin
            if (mstate[k] == M_RUN && fetch_req) begin
                evalid[k] = 1'b1;
                if (int'(fetch_addr) >= d) begin
                    einstr[k] = FILL; eperr[k] = 1'b0;
                end else if (mbad[k][fetch_addr]) begin
                    einstr[k] = FILL; eperr[k] = 1'b1;
                end else begin
                    einstr[k] = mmem[k][fetch_addr]; eperr[k] = 1'b0;
                end
            end else begin
                evalid[k] = 1'b0;
                eperr[k]  = 1'b0;
            end
        end
        case (mstate[k])
            M_INIT: begin
                mmem[k][micnt[k]] = FILL;
                mbad[k][micnt[k]] = 1'b0;
                micnt[k]++;
                if (micnt[k] == d) mstate[k] = M_RUN;
            end
            M_RUN: begin
                if (ld_start) begin
                    mstate[k] = M_LOAD;
                    mptr[k]   = int'(ld_base) % d;
                end
            end
            default: begin
                if (ld_valid) begin
                    mmem[k][mptr[k]] = ld_data;
`ifdef INSTR_PARITY_EN
                    mbad[k][mptr[k]] = ld_par_inv;
`else
                    mbad[k][mptr[k]] = 1'b0;
`endif
                    mptr[k] = (mptr[k] + 1) % d;
                    if (ld_last) mstate[k] = M_RUN;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (instr_w[k] !== FILL || valid_w[k] !== 1'b0 || ready_w[k] !== 1'b0
                || busy_w[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset k=%0d instr=%h valid=%b ready=%b busy=%b (want %h 0 0 1)",
                         k, instr_w[k], valid_w[k], ready_w[k], busy_w[k], FILL);
            end
`ifdef INSTR_PARITY_EN
            n_tests++;
            if (perr_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_perr k=%0d got=%b want=0", k, perr_w[k]);
            end
`endif
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        for (int c = 1; c <= 258; c++) begin
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = 8'($urandom);
            stall      = ($urandom_range(0, 3) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (instr_w[k] !== einstr[k] || valid_w[k] !== evalid[k]
                    || busy_w[k] !== (mstate[k] != M_RUN)) begin
                    n_fail++;
                    $display("FAIL init c=%0d k=%0d instr=%h/%h valid=%b/%b busy=%b",
                             c, k, instr_w[k], einstr[k], valid_w[k], evalid[k], busy_w[k]);
                end
            end
            if (c == 199 || c == 200 || c == 255 || c == 256) begin
                n_tests++;
                if (busy_w[0] !== (c < 256) || busy_w[1] !== (c < 200)) begin
                    n_fail++;
                    $display("FAIL busy_edge c=%0d busy0=%b busy1=%b want %b %b",
                             c, busy_w[0], busy_w[1], c < 256, c < 200);
                end
            end
        end
        fetch_req = 1'b0;
        stall     = 1'b0;
        tick();
    endtask

    task automatic test_fill_fetch();
        logic [7:0] addrs [4] = '{8'h00, 8'h7F, 8'hFF, 8'hC8};
        for (int i = 0; i < 4; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = addrs[i];
            tick();
            n_tests++;
            if (instr_w[0] !== FILL || valid_w[0] !== 1'b1 || instr_w[1] !== FILL
                || valid_w[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_fetch a=%h instr0=%h instr1=%h valid=%b%b want %h 11",
                         addrs[i], instr_w[0], instr_w[1], valid_w[0], valid_w[1], FILL);
            end
        end
        fetch_req = 1'b0;
        tick();
        n_tests++;
        if (valid_w[0] !== 1'b0 || instr_w[0] !== FILL) begin
            n_fail++;
            $display("FAIL idle_hold valid=%b instr=%h want 0 %h", valid_w[0], instr_w[0], FILL);
        end
    endtask

    task automatic do_load(input logic [7:0] base, input int beats, input logic [20:0] first);
        ld_start = 1'b1;
        ld_base  = base;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < beats; i++) begin
            ld_valid  = 1'b1;
            ld_data   = first + 21'(i);
            ld_last   = (i == beats - 1);
            fetch_req = 1'b1;
            fetch_addr = 8'h00;
            tick();
        end
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        fetch_req = 1'b0;
    endtask

    task automatic test_load_wrap();
        logic [7:0] addrs [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        ld_start = 1'b1;
        ld_base  = 8'hFE;
        tick();
        ld_start = 1'b0;
        n_tests++;
        if (ready_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL load_enter ready=%b busy=%b want 1 1", ready_w[0], busy_w[0]);
        end
        for (int i = 1; i <= 4; i++) begin
            ld_valid   = 1'b1;
            ld_data    = 21'(i);
            ld_last    = (i == 4);
            fetch_req  = 1'b1;
            fetch_addr = 8'h10;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (valid_w[k] !== evalid[k] || ready_w[k] !== (mstate[k] == M_LOAD)
                    || busy_w[k] !== (mstate[k] != M_RUN)) begin
                    n_fail++;
                    $display("FAIL load_beat i=%0d k=%0d valid=%b/%b ready=%b busy=%b",
                             i, k, valid_w[k], evalid[k], ready_w[k], busy_w[k]);
                end
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_addr = addrs[i];
            tick();
            n_tests++;
            if (instr_w[0] !== 21'(i + 1) || valid_w[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL load_wrap a=%h got=%h want=%h valid=%b", addrs[i], instr_w[0],
                         21'(i + 1), valid_w[0]);
            end
            n_tests++;
            if (instr_w[1] !== einstr[1] || valid_w[1] !== evalid[1]) begin
                n_fail++;
                $display("FAIL load_wrap_d200 a=%h got=%h want=%h", addrs[i], instr_w[1],
                         einstr[1]);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        do_load(8'h05, 1, 21'h155AA);
        fetch_req  = 1'b1;
        fetch_addr = 8'h01;
        tick();
        for (int i = 0; i < 3; i++) begin
            stall      = 1'b1;
            fetch_addr = 8'h05;
            tick();
            n_tests++;
            if (instr_w[0] !== 21'h000004 || valid_w[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold i=%0d instr=%h valid=%b want 000004 1", i, instr_w[0],
                         valid_w[0]);
            end
        end
        stall     = 1'b0;
        fetch_req = 1'b0;
        tick();
        n_tests++;
        if (valid_w[0] !== 1'b0 || instr_w[0] !== 21'h000004) begin
            n_fail++;
            $display("FAIL stall_drop valid=%b instr=%h want 0 000004", valid_w[0], instr_w[0]);
        end
        fetch_req = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (instr_w[k] !== 21'h155AA || valid_w[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_reissue k=%0d instr=%h valid=%b want 155aa 1", k,
                         instr_w[k], valid_w[k]);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_depth200();
        logic [7:0] addrs [3] = '{8'd199, 8'd0, 8'hC8};
        logic [20:0] want [3] = '{21'h0AAA1, 21'h0AAA2, FILL};
        do_load(8'd199, 2, 21'h0AAA1);
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = addrs[i];
            tick();
            n_tests++;
            if (instr_w[1] !== want[i] || valid_w[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL depth200 a=%0d got=%h want=%h valid=%b", addrs[i], instr_w[1],
                         want[i], valid_w[1]);
            end
            n_tests++;
            if (instr_w[0] !== einstr[0]) begin
                n_fail++;
                $display("FAIL depth256_ref a=%0d got=%h want=%h", addrs[i], instr_w[0],
                         einstr[0]);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            stall      = ($urandom_range(0, 3) == 0);
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = 8'($urandom);
            ld_start   = ($urandom_range(0, 19) == 0);
            ld_base    = 8'($urandom);
            ld_valid   = 1'($urandom_range(0, 1));
            ld_data    = 21'($urandom);
            ld_last    = ($urandom_range(0, 3) == 0);
`ifdef INSTR_PARITY_EN
            ld_par_inv = ($urandom_range(0, 7) == 0);
`endif
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (instr_w[k] !== einstr[k] || valid_w[k] !== evalid[k]
                    || busy_w[k] !== (mstate[k] != M_RUN)
                    || ready_w[k] !== (mstate[k] == M_LOAD)) begin
                    n_fail++;
                    $display("FAIL random c=%0d k=%0d instr=%h/%h valid=%b/%b busy=%b ready=%b",
                             c, k, instr_w[k], einstr[k], valid_w[k], evalid[k], busy_w[k],
                             ready_w[k]);
                end
`ifdef INSTR_PARITY_EN
                n_tests++;
                if (perr_w[k] !== eperr[k]) begin
                    n_fail++;
                    $display("FAIL random_perr c=%0d k=%0d got=%b want=%b", c, k, perr_w[k],
                             eperr[k]);
                end
`endif
            end
        end
        ld_start   = 1'b0;
        stall      = 1'b0;
        fetch_req  = 1'b0;
        ld_par_inv = 1'b0;
        ld_valid   = 1'b1;
        ld_last    = 1'b1;
        for (int c = 0; c < 4 && (mstate[0] != M_RUN || mstate[1] != M_RUN); c++) tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_tests++;
        if (busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain busy=%b%b want 00", busy_w[0], busy_w[1]);
        end
    endtask

    task automatic test_reset_mid_load();
        ld_start = 1'b1;
        ld_base  = 8'h40;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 21'h11111 * 21'(i + 1);
            tick();
        end
        ld_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (busy_w[0] !== 1'b1 || ready_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reset busy=%b ready=%b valid=%b want 1 0 0", busy_w[0],
                     ready_w[0], valid_w[0]);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 256; c++) tick();
        n_tests++;
        if (busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_refill busy=%b want 0", busy_w[0]);
        end
        fetch_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fetch_addr = 8'h40 + 8'(i);
            tick();
            n_tests++;
            if (instr_w[0] !== FILL || valid_w[0] !== 1'b1 || instr_w[1] !== einstr[1]) begin
                n_fail++;
                $display("FAIL midload_fetch a=%h got=%h want=%h valid=%b", fetch_addr,
                         instr_w[0], FILL, valid_w[0]);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

`ifdef INSTR_PARITY_EN
    task automatic test_parity();
        ld_start = 1'b1;
        ld_base  = 8'h10;
        tick();
        ld_start   = 1'b0;
        ld_valid   = 1'b1;
        ld_data    = 21'h0ABCDE;
        ld_par_inv = 1'b1;
        tick();
        ld_data    = 21'h011111;
        ld_par_inv = 1'b0;
        ld_last    = 1'b1;
        tick();
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 8'h10;
        tick();
        n_tests++;
        if (instr_w[0] !== FILL || perr_w[0] !== 1'b1 || valid_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad instr=%h perr=%b valid=%b want %h 1 1", instr_w[0],
                     perr_w[0], valid_w[0], FILL);
        end
        fetch_addr = 8'h11;
        tick();
        n_tests++;
        if (instr_w[0] !== 21'h011111 || perr_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_good instr=%h perr=%b want 011111 0", instr_w[0], perr_w[0]);
        end
        fetch_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) begin
                mmem[k][a] = FILL;
                mbad[k][a] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        test_reset();
        test_init();
        test_fill_fetch();
        test_load_wrap();
        test_stall();
        test_depth200();
`ifdef INSTR_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
